// File: rtl/scan_chain_driver.sv
// ---------------------------------------------------------------------------
// scan_chain_driver
//
// Tester-side controller for one scan chain of negative-edge scan flops.
// A run shifts PATTERN into the chain MSB first, fires one functional
// capture cycle, then unloads the chain while shifting FILL in. The captured
// response comes back as a parallel word on RESPONSE.
//
// Parameters
//   CHAIN_LEN : number of scan cells (N >= 2)
//   FILL      : value driven on SI while the chain is unloaded
//
// Ports
//   CLK       in   rising-edge clock (same net as the chain clock)
//   RSTB      in   synchronous active-low reset
//   START     in   run request, only looked at in IDLE
//   ABORT     in   cancel the current run (no effect in IDLE)
//   PATTERN   in   load pattern, copied when START is accepted
//   SO        in   chain scan-out (Q of cell N-1)
//   SE        out  scan enable to every cell
//   SI        out  scan-in to cell 0
//   BUSY      out  high in SHIFT, CAPTURE and UNLOAD
//   DONE      out  one-cycle pulse, RESPONSE is fresh in that cycle
//   RESPONSE  out  captured chain contents of the last completed run
//   DBG_STATE out  current FSM state (IDLE encodes as 0)
//
// Handshake: START is a level sampled on a rising edge while the FSM is
// IDLE; the edge that sees START=1 in IDLE is the acceptance edge. There is
// no queueing -- START seen in any other state is dropped. DONE is a
// single-cycle strobe with no acknowledge.
//
// Timing (T = acceptance edge): the cycle after edge T is SHIFT cycle 1.
// SHIFT occupies N cycles, CAPTURE 1, UNLOAD N, DONE 1, then IDLE. All
// outputs come straight from flops. The chain samples on the falling edge,
// so SE/SI get half a cycle of setup and SO half a cycle to settle.
// ---------------------------------------------------------------------------
module scan_chain_driver #(
  parameter int   CHAIN_LEN = 16,
  parameter logic FILL      = 1'b0
) (
  input  logic                 CLK,
  input  logic                 RSTB,
  input  logic                 START,
  input  logic                 ABORT,
  input  logic [CHAIN_LEN-1:0] PATTERN,
  input  logic                 SO,
  output logic                 SE,
  output logic                 SI,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [CHAIN_LEN-1:0] RESPONSE,
  output logic [2:0]           DBG_STATE
);

  // Counter only ever holds 0..N-1; this width also fits N itself.
  localparam int               CNT_W    = $clog2(CHAIN_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SHIFT   = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_UNLOAD  = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  // State and datapath registers
  logic [2:0]           r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [CHAIN_LEN-1:0] r_load;
  logic [CHAIN_LEN-1:0] r_resp_sh;
  logic [CHAIN_LEN-1:0] r_response;
  logic                 r_se;
  logic                 r_si;
  logic                 r_busy;
  logic                 r_done;

  // Next-state values
  logic [2:0]           w_state_nxt;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic [CHAIN_LEN-1:0] w_load_nxt;
  logic [CHAIN_LEN-1:0] w_resp_sh_nxt;
  logic [CHAIN_LEN-1:0] w_response_nxt;
  logic                 w_si_nxt;
  logic                 w_se_nxt;
  logic                 w_busy_nxt;
  logic                 w_done_nxt;
  logic                 w_sample;
  logic                 w_cnt_last;

  assign w_cnt_last = (r_cnt == CNT_LAST);

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_load_nxt     = r_load;
    w_response_nxt = r_response;
    w_si_nxt       = 1'b0;
    w_sample       = 1'b0;

    if (ABORT && (r_state != S_IDLE)) begin
      // Abort beats every other transition; nothing is sampled or published.
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (START) begin
            w_state_nxt = S_SHIFT;
            w_cnt_nxt   = '0;
            // The MSB goes out in the first SHIFT cycle, so the load
            // register holds the remaining bits already left-justified.
            w_si_nxt    = PATTERN[CHAIN_LEN-1];
            w_load_nxt  = {PATTERN[CHAIN_LEN-2:0], 1'b0};
          end
        end

        S_SHIFT: begin
          if (w_cnt_last) begin
            w_state_nxt = S_CAPTURE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt   = r_cnt + CNT_W'(1);
            w_si_nxt    = r_load[CHAIN_LEN-1];
            w_load_nxt  = {r_load[CHAIN_LEN-2:0], 1'b0};
          end
        end

        S_CAPTURE: begin
          // The chain captured on the falling edge inside this cycle, so SO
          // already shows cell N-1: that is response sample 1.
          w_state_nxt = S_UNLOAD;
          w_cnt_nxt   = '0;
          w_si_nxt    = FILL;
          w_sample    = 1'b1;
        end

        S_UNLOAD: begin
          if (w_cnt_last) begin
            // All N samples are in (the last UNLOAD edge takes none).
            w_state_nxt    = S_DONE;
            w_cnt_nxt      = '0;
            w_response_nxt = r_resp_sh;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
            w_si_nxt  = FILL;
            w_sample  = 1'b1;
          end
        end

        S_DONE: begin
          w_state_nxt = S_IDLE;
        end

        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end

    // Samples arrive cell N-1 first, so shifting in at the LSB leaves
    // cell i at bit i once all N are collected.
    if (w_sample) begin
      w_resp_sh_nxt = {r_resp_sh[CHAIN_LEN-2:0], SO};
    end else begin
      w_resp_sh_nxt = r_resp_sh;
    end

    w_se_nxt   = (w_state_nxt == S_SHIFT) || (w_state_nxt == S_UNLOAD);
    w_busy_nxt = (w_state_nxt == S_SHIFT) || (w_state_nxt == S_CAPTURE) ||
                 (w_state_nxt == S_UNLOAD);
    w_done_nxt = (w_state_nxt == S_DONE);
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!RSTB) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_load     <= '0;
      r_resp_sh  <= '0;
      r_response <= '0;
      r_se       <= 1'b0;
      r_si       <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_load     <= w_load_nxt;
      r_resp_sh  <= w_resp_sh_nxt;
      r_response <= w_response_nxt;
      r_se       <= w_se_nxt;
      r_si       <= w_si_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
    end
  end

  assign SE        = r_se;
  assign SI        = r_si;
  assign BUSY      = r_busy;
  assign DONE      = r_done;
  assign RESPONSE  = r_response;
  assign DBG_STATE = r_state;

endmodule

// File: doc/scan_chain_driver.md
# scan_chain_driver

Tester-side controller for one scan chain built from negative-edge scan flops (SE/SI/SO style, as in the SDFFN* cells). On request it shifts a parallel pattern into the chain, fires one functional capture cycle, then shifts the chain out and returns the captured response as a parallel word. It sits between the test-control logic and the chain's SE, SI and SO pins, and is the driving and observing end of the chain's scan interface.

## Interface
- CHAIN_LEN, 16: number of scan cells in the chain (N ≥ 2).
- FILL, 1'b0: value driven on SI during unload.
- CNT_W, $clog2(CHAIN_LEN+1): bit-counter width (derived; not overridden).

Ports:
- CLK  in  1  rising-edge clock, same net as the chain's CLK.
- RSTB  in  1  reset: one clock, synchronous, active-low.
- START  in  1  run request; sampled only in IDLE.
- ABORT  in  1  cancel the current run; has effect in any state except IDLE.
- PATTERN  in  CHAIN_LEN  load pattern; captured on START acceptance.
- SO  in  1  chain scan-out (Q of cell N-1).
- SE  out  1  scan enable to every chain cell.
- SI  out  1  scan-in to cell 0.
- BUSY  out  1  high in SHIFT, CAPTURE and UNLOAD.
- DONE  out  1  one-cycle pulse when RESPONSE is valid.
- RESPONSE  out  CHAIN_LEN  captured chain contents from the last completed run.

## Operation
- Cell numbering: cell 0 is driven by SI; cell N-1 drives SO. After load, cell i holds PATTERN[i]. RESPONSE[i] is the value cell i captured.
- States:
  - IDLE: SE=0, SI=0.
  - SHIFT: N cycles. SE=1. SI = pattern bit, MSB first: PATTERN[N-1] in the first cycle, PATTERN[0] in the last.
  - CAPTURE: 1 cycle. SE=0, SI=0.
  - UNLOAD: N cycles. SE=1, SI=FILL.
  - DONE: 1 cycle. DONE=1, SE=0.
  - After DONE, the FSM returns to IDLE.
- Transitions:
  - IDLE→SHIFT on START=1. On that edge, PATTERN is copied into an internal load shift register.
  - SHIFT→CAPTURE and UNLOAD→DONE when the bit counter reaches N-1. The counter resets to 0 on entry to each of those states.
- Response collection:
  - SO is sampled on N consecutive rising edges, k = 1..N. Edge 1 is the edge leaving CAPTURE; the remaining N-1 edges are the first N-1 UNLOAD edges.
  - Sample k is cell N-k, shifted MSB-first into an internal response register.
  - RESPONSE is loaded from that register on the edge entering DONE. RESPONSE changes only then and on reset.
- ABORT=1 outside IDLE:
  - Next state is IDLE; SE=0 from that edge.
  - No DONE pulse; RESPONSE is unchanged.
  - ABORT takes priority over any same-edge transition.
- START while BUSY or in DONE is ignored. It is not queued. START and ABORT together in IDLE: START wins, because ABORT has no effect in IDLE.
- After UNLOAD, every chain cell holds FILL.

## Timing
- All outputs are registered on the rising edge of CLK. The chain samples on the falling edge, so SE/SI have a half-cycle of setup and SO has a half-cycle to settle before the controller's rising-edge sample.
- Reset (RSTB=0 at a rising edge) puts the block in IDLE with SE=0, SI=0, BUSY=0, DONE=0, RESPONSE=0, and clears the counter and internal registers.
  - Reset mid-run has the same effect. No DONE pulse is produced.
- Let T be the edge that accepts START.
  - BUSY=1 in cycles T+1..T+2N+1.
  - DONE=1 in cycle T+2N+2.
  - IDLE again at T+2N+3, so a new START can be accepted at edge T+2N+3 at the earliest.
- SE pattern per run: N cycles at 1, 1 cycle at 0, N cycles at 1.
- The counter never exceeds N-1. CNT_W covers N=CHAIN_LEN exactly at powers of two.

## Test plan
Bench model for all scenarios: a behavioral chain of CHAIN_LEN=4 negedge scan flops, with each cell's D input driven from bench vector CAPT_D.

- PATTERN=4'b1010, START pulse, CAPT_D=4'b0110:
  - Chain holds 4'b1010 during CAPTURE.
  - SI sequence in SHIFT is 1,0,1,0.
  - DONE at T+10 with RESPONSE=4'b0110.
  - BUSY high for exactly 9 cycles.
- Back-to-back runs (PATTERN=4'hF/CAPT_D=4'h3, then 4'h0/4'hC), second START at the earliest legal edge:
  - RESPONSE=4'h3, then 4'hC.
  - START held high during run 1 starts nothing extra.
- ABORT in UNLOAD cycle 2, with RESPONSE holding 4'h5 from a prior run:
  - Next edge: IDLE, SE=0.
  - No DONE; RESPONSE stays 4'h5.
- RSTB=0 during SHIFT:
  - Next edge: all outputs 0, RESPONSE=0.
  - A later run with PATTERN=4'h9/CAPT_D=4'h9 returns 4'h9.
- FILL=1, CAPT_D=4'b0001:
  - RESPONSE=4'b0001.
  - Chain reads 4'hF after DONE.
  - SE trace: 1,1,1,1,0,1,1,1,1.
